// File: rtl/trace_bridge_pkg.sv
// rtl/trace_bridge_pkg.sv - shared types and constants for the trace UART bridge
// Purpose: TX state encoding and UART framing constants.
// Ports: none (package).
package trace_bridge_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - single-clock byte FIFO with occupancy counter
// Purpose: power-of-two byte FIFO; pushes while full and pops while empty are ignored.
// Ports:
//   clk, rst      clock, asynchronous active-low reset (pointers and fill only)
//   push_i/data_i write strobe and byte
//   pop_i/data_o  read strobe and head-of-queue byte (valid while !empty_o)
//   fill_o        occupancy 0..DEPTH
//   full_o/empty_o status flags derived from the registered fill
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [7:0]             data_i,
  input  logic                   pop_i,
  output logic [7:0]             data_o,
  output logic [$clog2(DEPTH):0] fill_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   fill_q;
  logic             do_push, do_pop;

  assign full_o  = (fill_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (fill_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign fill_o  = fill_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end

  // Storage is not reset; resetting the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/trace_uart_bridge.sv
// rtl/trace_uart_bridge.sv - buffered trace byte stream to 8N1/8N2 UART transmitter
// Purpose: FIFO-buffers trace bytes, counts bytes dropped while full, serialises
//          the FIFO onto a UART line. Optional host CTS gating when the macro
//          TRACE_BRIDGE_CTS_EN is defined.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   in_valid/in_data one-cycle trace byte strobe
//   ovf_clr         synchronous clear of ovf and drop_cnt (wins over a same-cycle drop)
//   cts_n           host clear-to-send, active-low, async (TRACE_BRIDGE_CTS_EN only)
//   tx              UART serial output, idles high
//   busy            high while a frame is on the line
//   fill            FIFO occupancy
//   ovf, drop_cnt   sticky drop flag and saturating drop counter
module trace_uart_bridge
  import trace_bridge_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 612,
  parameter int STOP_BITS    = 1,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  input  logic                   ovf_clr,
`ifdef TRACE_BRIDGE_CTS_EN
  input  logic                   cts_n,
`endif
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   ovf,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int            TMR_W    = $clog2(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);

  logic       fifo_full, fifo_empty, pop;
  logic [7:0] fifo_head;
  logic       drop, cts_ok, start_ok, tick;

  tx_state_t        state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ovf_q;
  logic [CNT_W-1:0] drop_cnt_q;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .data_i  (in_data),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .fill_o  (fill),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Full is the registered state, so a write while full is dropped even if
  // the transmitter pops in the same cycle.
  assign drop = in_valid && fifo_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else if (ovf_clr) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

`ifdef TRACE_BRIDGE_CTS_EN
  logic cts_meta_q, cts_sync_q;

  // Reset to "not clear" so nothing is sent before the host has been seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= cts_n;
      cts_sync_q <= cts_meta_q;
    end
  end

  assign cts_ok = !cts_sync_q;
`else
  assign cts_ok = 1'b1;
`endif

  assign start_ok = !fifo_empty && cts_ok;
  assign tick     = (timer_q == TMR_LAST);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (start_ok) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          state_d = START;
        end
      end
      START: begin
        timer_d = tick ? '0 : timer_q + 1'b1;
        if (tick) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        timer_d = tick ? '0 : timer_q + 1'b1;
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'(UART_DATA_BITS - 1)) begin
            state_d = STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        timer_d = tick ? '0 : timer_q + 1'b1;
        if (tick) begin
          if (idx_q == 3'(STOP_BITS - 1)) begin
            // Last stop cycle: chain straight into the next frame if possible.
            if (start_ok) begin
              pop     = 1'b1;
              shift_d = fifo_head;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered from next-state so the line carries no decode glitches.
  always_comb begin
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign ovf      = ovf_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_trace_uart_bridge.sv
// tb/tb_trace_uart_bridge.sv - scoreboard bench for trace_uart_bridge
module tb_trace_uart_bridge;

  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int SB    = 1;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             ovf_clr = 1'b0;
`ifdef TRACE_BRIDGE_CTS_EN
  logic             cts_n = 1'b0;
`endif
  logic             tx, busy, ovf;
  logic [2:0]       fill;
  logic [CNT_W-1:0] drop_cnt;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         peak;
  logic [7:0] exp_q[$];
  int         starts[$];

  trace_uart_bridge #(
    .DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .STOP_BITS(SB), .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .ovf_clr  (ovf_clr),
`ifdef TRACE_BRIDGE_CTS_EN
    .cts_n    (cts_n),
`endif
    .tx       (tx),
    .busy     (busy),
    .fill     (fill),
    .ovf      (ovf),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: decode every frame on tx (mid-bit sampling) and pop the scoreboard.
  initial begin : monitor
    logic [7:0] got;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (rst && tx === 1'b0) begin
        starts.push_back(cyc);
        aborted = 1'b0;
        got = 8'h00;
        repeat (2) @(negedge clk);
        if (!rst) aborted = 1'b1;
        else check("start_bit", 32'(tx), 32'd0);
        for (int j = 0; j < 8; j++) begin
          if (!aborted) begin
            repeat (4) @(negedge clk);
            if (!rst) aborted = 1'b1;
            else got[j] = tx;
          end
        end
        if (!aborted) begin
          repeat (4) @(negedge clk);
          if (!rst) aborted = 1'b1;
          else check("stop_bit", 32'(tx), 32'd1);
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame: got byte 0x%0h, required no frame", got);
          end else begin
            check("frame_byte", 32'(got), 32'(exp_q.pop_front()));
          end
          @(negedge clk);
        end
      end
    end
  end

  // n consecutive one-cycle strobes of base, base+1, ...; the first 'keep' are
  // expected on the line, the rest are expected to be dropped.
  task automatic burst(input int n, input logic [7:0] base, input int keep);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      if (i < keep) exp_q.push_back(in_data);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output int pk);
    logic done;
    done = 1'b0;
    pk = 0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if (int'(fill) > pk) pk = int'(fill);
      if (!busy && fill == 3'd0 && exp_q.size() == 0) done = 1'b1;
    end
    check("idle_reached", 32'(done), 32'd1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte 0xA5: fill=1 at N+1, tx low at N+2, busy for 40 cycles
    burst(1, 8'hA5, 1);
    @(negedge clk);
    check("single_fill_n1", 32'(fill), 32'd1);
    check("single_tx_n1", 32'(tx), 32'd1);
    @(negedge clk);
    check("single_tx_n2", 32'(tx), 32'd0);
    check("single_busy_n2", 32'(busy), 32'd1);
    repeat (39) @(negedge clk);
    check("single_busy_last", 32'(busy), 32'd1);
    @(negedge clk);
    check("single_busy_end", 32'(busy), 32'd0);
    check("single_tx_end", 32'(tx), 32'd1);
    wait_idle(50, peak);

    // Back-to-back 0x01,0x02,0x03
    starts.delete();
    burst(3, 8'h01, 3);
    wait_idle(400, peak);
    check("b2b_peak_fill", 32'(peak), 32'd2);
    check("b2b_frames", 32'(starts.size()), 32'd3);
    if (starts.size() == 3) begin
      check("b2b_gap1", 32'(starts[1] - starts[0]), 32'd40);
      check("b2b_gap2", 32'(starts[2] - starts[1]), 32'd40);
    end

    // Overflow: 7 strobes, 5 sent, 2 dropped
    burst(7, 8'h10, 5);
    @(negedge clk);
    check("ovf_fill", 32'(fill), 32'd4);
    check("ovf_flag", 32'(ovf), 32'd1);
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    @(negedge clk);
    check("ovf_clr_flag", 32'(ovf), 32'd0);
    check("ovf_clr_cnt", 32'(drop_cnt), 32'd0);
    wait_idle(600, peak);

    // Saturation: 20 drops on a 4-bit counter, then clear wins over a drop
    burst(25, 8'h40, 5);
    @(negedge clk);
    check("sat_drop_cnt", 32'(drop_cnt), 32'd15);
    check("sat_ovf", 32'(ovf), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    ovf_clr  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ovf_clr  = 1'b0;
    @(negedge clk);
    check("clr_prio_cnt", 32'(drop_cnt), 32'd0);
    check("clr_prio_ovf", 32'(ovf), 32'd0);
    check("clr_prio_fill", 32'(fill), 32'd4);
    wait_idle(800, peak);

`ifdef TRACE_BRIDGE_CTS_EN
    // CTS: hold off, release, then assert mid-frame
    begin
      int  lat;
      logic seen;
      cts_n = 1'b1;
      repeat (4) @(negedge clk);
      burst(1, 8'h55, 1);
      repeat (10) @(negedge clk);
      check("cts_hold_fill", 32'(fill), 32'd1);
      check("cts_hold_busy", 32'(busy), 32'd0);
      check("cts_hold_tx", 32'(tx), 32'd1);
      cts_n = 1'b0;
      lat  = 0;
      seen = 1'b0;
      for (int i = 1; i <= 6 && !seen; i++) begin
        @(negedge clk);
        if (tx == 1'b0) begin
          seen = 1'b1;
          lat  = i;
        end
      end
      check("cts_start_seen", 32'(seen), 32'd1);
      check("cts_start_within_4", 32'(lat <= 4), 32'd1);
      repeat (8) @(negedge clk);
      cts_n = 1'b1;
      wait_idle(200, peak);
      cts_n = 1'b0;
      repeat (4) @(negedge clk);
    end
`endif

    // Reset during DATA: async return to idle, FIFO contents discarded
    begin
      logic seen;
      seen = 1'b0;
      burst(2, 8'hC3, 2);
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        if (tx == 1'b0) seen = 1'b1;
      end
      check("rstmid_frame_started", 32'(seen), 32'd1);
      repeat (10) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check("rstmid_tx", 32'(tx), 32'd1);
      check("rstmid_fill", 32'(fill), 32'd0);
      check("rstmid_busy", 32'(busy), 32'd0);
      exp_q.delete();
      repeat (6) @(negedge clk);
      rst = 1'b1;
      starts.delete();
      repeat (60) @(negedge clk);
      check("rstmid_no_resume", 32'(starts.size()), 32'd0);
      check("rstmid_idle_busy", 32'(busy), 32'd0);
      check("rstmid_idle_tx", 32'(tx), 32'd1);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_uart_bridge.md
# trace_uart_bridge

Buffered, parametrised bridge between the trace byte stream (output of `traceIF`) and a serial UART line. Incoming trace bytes are written into a power-of-two FIFO and serialised 8N1/8N2 at a fixed divisor. Dropped bytes are counted and flagged because the trace side cannot be stalled. Optional host CTS flow control is provided. It replaces the direct `traceIF` → `uart` transmit coupling in the orbtrace top level.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `CLKS_PER_BIT`, 612: clk cycles per UART bit; ≥2. The default gives ≈115200 baud at 70.5 MHz.
- `STOP_BITS`, 1: number of stop bits; 1 or 2.
- `CNT_W`, 16: width of the dropped-byte counter.

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: one-cycle strobe; `in_data` is valid.
- `in_data` in 8: trace byte.
- `ovf_clr` in 1: synchronous clear of `ovf` and `drop_cnt`.
- `cts_n` in 1: host clear-to-send, active-low, asynchronous to clk. Present only with `TRACE_BRIDGE_CTS_EN`.
- `tx` out 1: UART serial output; idles high.
- `busy` out 1: high while a frame is on the line.
- `fill` out $clog2(DEPTH)+1: current FIFO occupancy.
- `ovf` out 1: sticky; set when at least one byte has been dropped.
- `drop_cnt` out CNT_W: number of dropped bytes; saturates at all-ones.

## Operation
- **Reset values** while `rst`=0: `tx`=1, `busy`=0, `fill`=0, `ovf`=0, `drop_cnt`=0; FSM in IDLE; FIFO pointers 0.
- **Write:** `in_valid`=1 with `fill`<DEPTH stores the byte. `in_valid`=1 with `fill`==DEPTH drops the byte, sets `ovf`, and increments `drop_cnt` (saturating).
- **Full is judged on registered `fill`.** A write arriving while full is dropped even if a pop occurs in the same cycle. A simultaneous push and pop with `fill`<DEPTH leaves `fill` unchanged.
- **`ovf_clr` vs drop:** `ovf_clr` takes priority over a drop in the same cycle. Both fields clear and that drop is not counted.
- **Pointers** wrap modulo DEPTH; `fill` is a separate counter from 0 to DEPTH.
- **TX FSM:** IDLE → START → DATA → STOP → (IDLE | START).
  - IDLE: `tx`=1. When `fill`>0 (and CTS permits), pop the head into the shift register and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - STOP: `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles. In the final cycle, if `fill`>0 (and CTS permits), pop and go directly to START; otherwise go to IDLE.
- **`busy`**=1 in START, DATA and STOP.
- **Bit timer:** counts 0..CLKS_PER_BIT-1 and reloads on each bit boundary; no fractional divisor.

## Timing
- Byte strobed at cycle N into an empty FIFO while IDLE: `fill`=1 at N+1, pop at N+1, `tx` falls at N+2.
- A frame lasts (1+8+STOP_BITS)×CLKS_PER_BIT cycles. Back-to-back frames have no idle gap.
- `fill` decrements in the cycle after the pop and increments in the cycle after the write.
- **`cts_n`** passes through a 2-FF synchroniser, so it takes effect 2–3 cycles after the input edge. It is sampled only at the frame-start decision; a frame in progress always completes.
- **Reset mid-frame:** `tx` returns high asynchronously and the FIFO contents are discarded.

## Configuration
- **`TRACE_BRIDGE_CTS_EN` defined:**
  - The `cts_n` port and synchroniser exist.
  - A new frame starts only when the synchronised `cts_n`=0.
  - While `cts_n`=1 the FIFO keeps filling and overflows per the write rules.
- **Undefined:** no `cts_n` port; frames start whenever `fill`>0.

## Structure
- **Package `trace_bridge_pkg`:** `tx_state_t` enum (IDLE, START, DATA, STOP) and the `UART_DATA_BITS`=8 constant.
- **Sub-module `byte_fifo`:** parametrised by DEPTH. Provides synchronous single-clock push/pop, a `fill` output and a full/empty flag. It contains no drop logic.
- **`trace_uart_bridge`:** holds the drop counter, CTS synchroniser and TX FSM.

## Test plan
Bench parameters: DEPTH=4, CLKS_PER_BIT=4, STOP_BITS=1.
- **Single byte:** strobe 0xA5 at cycle 10 → `tx` low at cycle 12. Bits LSB-first are 1,0,1,0,0,1,0,1, 4 cycles each. Stop bit high. `busy` falls after 40 cycles.
- **Back-to-back:** 3 consecutive strobes 0x01, 0x02, 0x03 → three frames with no idle cycle between them; `fill` peaks at 2.
- **Overflow:** 7 strobes in 7 consecutive cycles → the first byte transmits, 4 bytes are buffered, 2 are dropped. `ovf`=1, `drop_cnt`=2. Then `ovf_clr` → both return to 0.
- **Saturation:** with CNT_W=4, drop 20 bytes → `drop_cnt` holds at 15.
- **CTS (macro defined):** `cts_n`=1, strobe 0x55 → no start bit and `fill`=1. Release `cts_n` → start bit within 4 cycles. Assert `cts_n` mid-frame → the frame completes.
- **Reset mid-frame:** drive `rst` low during DATA → `tx`=1, `fill`=0 and `busy`=0 immediately. No frame resumes after release.
